// File: rtl/writeback.sv
// Writeback stage: retires execute results into the register file and owns
// pipeline flush/redirect and halt-on-trap.
//
// Optional feature: define WRITEBACK_INSTRET_EN to add the 64-bit retired
// instruction counter output 'instret'. Without it the port and counter are absent.
//
// Handshake: result_valid/result_ready follow valid/ready semantics. A result
// transfers on a rising edge where both are 1. result_ready is tied to 1 because
// execute can never be stalled. A transferred result is discarded unless the
// FSM is in RUN.
//
// All outputs are registered, so a commit shows on the outputs one cycle
// after acceptance. state_dbg exposes the FSM state. commit_pc holds the pc of
// the most recently accepted RUN result.
module writeback #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  // decoupled exec_result input
  input  logic            result_valid,
  output logic            result_ready,
  input  logic [XLEN-1:0] result_pc,
  input  logic [4:0]      result_rd,
  input  logic [XLEN-1:0] result_rd_val,
  input  logic            result_wb_en,
  input  logic            result_redirect,
  input  logic [XLEN-1:0] result_redirect_pc,
  input  logic            result_trap,
  // register-file write port
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  // pipeline control
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            halted,
`ifdef WRITEBACK_INSTRET_EN
  output logic [63:0]     instret,
`endif
  // observability
  output logic [XLEN-1:0] commit_pc,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       commit;
  logic       do_write;
  logic       do_redirect;
  logic       do_trap;

  assign result_ready = 1'b1;
  assign state_dbg    = state;

  // Decode what the presented result does. Only RUN accepts commits, and a trap
  // overrides both the register write and any redirect.
  always_comb begin
    commit      = (state == RUN) && result_valid;
    do_trap     = commit && result_trap;
    do_write    = commit && !result_trap && result_wb_en && (result_rd != 5'd0);
    do_redirect = commit && !result_trap && result_redirect;
  end

  // FSM next state. FLUSH lasts exactly one cycle. HALT is left only by reset.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (do_trap)          state_nxt = HALT;
        else if (do_redirect) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = RUN;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // State and one-cycle strobes. Reset presents a flush plus a redirect to
  // RESET_PC, so fetch starts cleanly once reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      rf_we          <= 1'b0;
      flush          <= 1'b1;
      redirect_valid <= 1'b1;
      halted         <= 1'b0;
    end else begin
      state          <= state_nxt;
      rf_we          <= do_write;
      flush          <= do_redirect || do_trap;
      redirect_valid <= do_redirect;
      halted         <= (state_nxt == HALT);
    end
  end

  // Payload registers. Each one only loads with its strobe and holds its value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_waddr    <= 5'd0;
      rf_wdata    <= '0;
      redirect_pc <= RESET_PC;
      commit_pc   <= '0;
    end else begin
      if (do_write) begin
        rf_waddr <= result_rd;
        rf_wdata <= result_rd_val;
      end
      if (do_redirect) begin
        redirect_pc <= result_redirect_pc;
      end
      if (commit) begin
        commit_pc <= result_pc;
      end
    end
  end

`ifdef WRITEBACK_INSTRET_EN
  logic [63:0] instret_q;

  assign instret = instret_q;

  // Count every non-trapping RUN commit, including commits that do not write
  // the register file. The counter wraps naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else if (commit && !result_trap) begin
      instret_q <= instret_q + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback. Driver tasks queue hand-computed expected
// outputs, and a negedge monitor pops one entry per cycle and compares it.
module tb_writeback;

  localparam int XLEN = 32;
  localparam int W    = 75;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic            clk;
  logic            rst;
  logic            result_valid;
  logic            result_ready;
  logic [31:0]     result_pc;
  logic [4:0]      result_rd;
  logic [31:0]     result_rd_val;
  logic            result_wb_en;
  logic            result_redirect;
  logic [31:0]     result_redirect_pc;
  logic            result_trap;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            flush;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            halted;
  logic [31:0]     commit_pc;
  logic [1:0]      state_dbg;
`ifdef WRITEBACK_INSTRET_EN
  logic [63:0]     instret;
`endif

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks;
  int           errors;
  int           pc_ctr;

  writeback #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_pc(result_pc),
    .result_rd(result_rd),
    .result_rd_val(result_rd_val),
    .result_wb_en(result_wb_en),
    .result_redirect(result_redirect),
    .result_redirect_pc(result_redirect_pc),
    .result_trap(result_trap),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted),
`ifdef WRITEBACK_INSTRET_EN
    .instret(instret),
`endif
    .commit_pc(commit_pc),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd,
                                      input logic fl, input logic rv,
                                      input logic [31:0] rpc, input logic h);
    return {st, we, wa, wd, fl, rv, rpc, h};
  endfunction

  function automatic logic [W-1:0] outs();
    return {state_dbg, rf_we, rf_waddr, rf_wdata, flush, redirect_valid, redirect_pc, halted};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("st=%0d we=%0d waddr=%0d wdata=%h flush=%0d rv=%0d rpc=%h halted=%0d",
                     v[74:73], v[72], v[71:67], v[66:35], v[34], v[33], v[32:1], v[0]);
  endfunction

  task automatic check_now(input string name, input logic [W-1:0] e);
    logic [W-1:0] g;
    g = outs();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %s required %s", name, fmt(g), fmt(e));
    end
  endtask

  task automatic check64(input string name, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %h required %h", name, g, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic vec(input string name, input logic v, input logic [4:0] rd,
                     input logic [31:0] val, input logic wb, input logic rdr,
                     input logic [31:0] rpc, input logic tr, input logic [W-1:0] e);
    @(negedge clk);
    #1;
    result_valid       = v;
    result_pc          = RESET_PC + 32'(pc_ctr * 4);
    result_rd          = rd;
    result_rd_val      = val;
    result_wb_en       = wb;
    result_redirect    = rdr;
    result_redirect_pc = rpc;
    result_trap        = tr;
    pc_ctr++;
    exp_q.push_back(e);
    tag_q.push_back(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    string        t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = outs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got %s required %s", t, fmt(g), fmt(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    pc_ctr = 0;
    result_valid = 0; result_pc = 0; result_rd = 0; result_rd_val = 0;
    result_wb_en = 0; result_redirect = 0; result_redirect_pc = 0; result_trap = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_now("reset_async", mk(RUN, 0, 0, 0, 1, 1, RESET_PC, 0));
    checks++;
    if (result_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready got %0d required 1", result_ready);
    end
    #15 rst = 1'b0;

    vec("post_reset",  0, 0, 0, 0, 0, 0, 0,                        mk(RUN,  0, 0, 0, 0, 0, RESET_PC, 0));
    vec("write_rd5",   1, 5, 32'hDEAD_BEEF, 1, 0, 0, 0,            mk(RUN,  1, 5, 32'hDEAD_BEEF, 0, 0, RESET_PC, 0));
    vec("idle_hold",   0, 0, 0, 0, 0, 0, 0,                        mk(RUN,  0, 5, 32'hDEAD_BEEF, 0, 0, RESET_PC, 0));
    vec("x0_suppress", 1, 0, 32'h1234, 1, 0, 0, 0,                 mk(RUN,  0, 5, 32'hDEAD_BEEF, 0, 0, RESET_PC, 0));
    vec("wb_en_off",   1, 7, 32'h55, 0, 0, 0, 0,                   mk(RUN,  0, 5, 32'hDEAD_BEEF, 0, 0, RESET_PC, 0));
    vec("redirect",    1, 1, 32'h1111_1111, 1, 1, 32'h8000_0040, 0, mk(FLUSH, 1, 1, 32'h1111_1111, 1, 1, 32'h8000_0040, 0));
    vec("wrong_path",  1, 2, 32'h2222_2222, 1, 0, 0, 0,            mk(RUN,  0, 1, 32'h1111_1111, 0, 0, 32'h8000_0040, 0));
    vec("after_flush", 1, 4, 32'h44, 1, 0, 0, 0,                   mk(RUN,  1, 4, 32'h44, 0, 0, 32'h8000_0040, 0));
    vec("redir_nowb",  1, 6, 32'h66, 0, 1, 32'h8000_0100, 0,        mk(FLUSH, 0, 4, 32'h44, 1, 1, 32'h8000_0100, 0));
    vec("flush_drop",  1, 8, 32'h88, 1, 1, 32'h9000_0000, 0,        mk(RUN,  0, 4, 32'h44, 0, 0, 32'h8000_0100, 0));
    vec("b2b_a",       1, 9, 32'h99, 1, 0, 0, 0,                   mk(RUN,  1, 9, 32'h99, 0, 0, 32'h8000_0100, 0));
    vec("b2b_b",       1, 10, 32'hAA, 1, 0, 0, 0,                  mk(RUN,  1, 10, 32'hAA, 0, 0, 32'h8000_0100, 0));
    vec("trap_redir",  1, 3, 32'h33, 1, 1, 32'h8000_0200, 1,        mk(HALT, 0, 10, 32'hAA, 1, 0, 32'h8000_0100, 1));
    for (int i = 0; i < 10; i++) begin
      vec("halt_drop", 1, 5'(11 + i), 32'(i), 1, i[0], 32'h8000_0300, 0,
          mk(HALT, 0, 10, 32'hAA, 0, 0, 32'h8000_0100, 1));
    end
    vec("halt_idle",   0, 0, 0, 0, 0, 0, 0,                        mk(HALT, 0, 10, 32'hAA, 0, 0, 32'h8000_0100, 1));
    drain();
`ifdef WRITEBACK_INSTRET_EN
    check64("instret_count", instret, 64'd8);
`endif

    // asynchronous reset mid-cycle while halted
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_now("reset_from_halt", mk(RUN, 0, 0, 0, 1, 1, RESET_PC, 0));
    @(posedge clk);
    #2 rst = 1'b0;
    vec("halt_release", 0, 0, 0, 0, 0, 0, 0,                       mk(RUN, 0, 0, 0, 0, 0, RESET_PC, 0));
    vec("first_commit", 1, 12, 32'h00C0_FFEE, 1, 0, 0, 0,          mk(RUN, 1, 12, 32'h00C0_FFEE, 0, 0, RESET_PC, 0));
    vec("redir_pre_rst", 1, 13, 32'h1313, 1, 1, 32'h8000_0300, 0,   mk(FLUSH, 1, 13, 32'h1313, 1, 1, 32'h8000_0300, 0));
    drain();
`ifdef WRITEBACK_INSTRET_EN
    check64("instret_after_reset", instret, 64'd2);
`endif

    // asynchronous reset while in FLUSH, with a write and redirect on the outputs
    rst = 1'b1;
    result_valid = 1'b0;
    #1;
    check_now("reset_mid_flush", mk(RUN, 0, 0, 0, 1, 1, RESET_PC, 0));
    @(posedge clk);
    #2 rst = 1'b0;
    vec("flush_release", 0, 0, 0, 0, 0, 0, 0,                      mk(RUN, 0, 0, 0, 0, 0, RESET_PC, 0));
    vec("commit_again", 1, 14, 32'h1414, 1, 0, 0, 0,               mk(RUN, 1, 14, 32'h1414, 0, 0, RESET_PC, 0));
    vec("idle_end",     0, 0, 0, 0, 0, 0, 0,                       mk(RUN, 0, 14, 32'h1414, 0, 0, RESET_PC, 0));
    drain();

`ifdef WRITEBACK_INSTRET_EN
    check64("instret_restart", instret, 64'd1);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    check64("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    vec("wrap_commit", 1, 0, 32'h0, 0, 0, 0, 0,                    mk(RUN, 0, 14, 32'h1414, 0, 0, RESET_PC, 0));
    vec("wrap_idle",   0, 0, 0, 0, 0, 0, 0,                        mk(RUN, 0, 14, 32'h1414, 0, 0, RESET_PC, 0));
    drain();
    check64("instret_wrap", instret, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data and PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the redirect target presented after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port result, decoupled.in of exec_result, carrying these exec_result fields:
- pc (XLEN)
- rd (5)
- rd_val (XLEN)
- wb_en (1)
- redirect (1)
- redirect_pc (XLEN)
- trap (1)
REQ-006 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-007 SHALL have port rf_waddr, output, 5 bits: register-file write address.
REQ-008 SHALL have port rf_wdata, output, XLEN bits: register-file write data.
REQ-009 SHALL have port flush, output, 1 bit: discard all younger in-flight instructions in upstream stages.
REQ-010 SHALL have port redirect_valid, output, 1 bit: the fetch PC is to be replaced.
REQ-011 SHALL have port redirect_pc, output, XLEN bits: the new fetch PC.
REQ-012 SHALL have port halted, output, 1 bit: the core has stopped on a trap.

Function
REQ-013 SHALL drive result.ready constantly 1, because the upstream execute stage is unblockable.
REQ-014 SHALL implement FSM states RUN, FLUSH and HALT.
REQ-015 SHALL commit in RUN on a cycle where result.valid=1 and commit the instruction presented.
REQ-016 SHALL register all outputs, so a commit appears on the outputs exactly 1 cycle after acceptance.
REQ-017 SHALL assert rf_we in the cycle after a commit when wb_en=1 and rd!=0, with rf_waddr=rd and rf_wdata=rd_val; otherwise rf_we=0.
REQ-018 SHALL never assert rf_we for rd=0, regardless of wb_en.
REQ-019 SHALL, on a RUN commit with redirect=1 and trap=0, do all of the following:
- perform the commit's register write;
- assert flush and redirect_valid for exactly 1 cycle, with redirect_pc=redirect_pc;
- move to FLUSH.
REQ-020 SHALL spend exactly 1 cycle in FLUSH, discard any result presented there (no rf_we, no redirect), and return to RUN.
REQ-021 SHALL, on a RUN commit with trap=1, do all of the following:
- suppress the register write;
- assert flush for 1 cycle;
- assert redirect_valid=0;
- move to HALT.
REQ-022 SHALL give trap priority over redirect when trap=1 and redirect=1 on the same commit.
REQ-023 SHALL, in HALT, hold halted=1, discard every result, and keep rf_we=0 and redirect_valid=0 until reset.
REQ-024 SHALL hold flush, redirect_valid and rf_we at 0 on cycles with no commit in RUN.
REQ-025 SHALL hold rf_waddr, rf_wdata and redirect_pc at their previous values while their qualifying strobe is 0.

Reset
REQ-026 SHALL, on rst assertion, immediately place the FSM in RUN regardless of the cycle or state.
REQ-027 SHALL, on rst assertion, immediately set rf_we=0, rf_waddr=0, rf_wdata=0 and halted=0.
REQ-028 SHALL, on rst assertion, immediately set flush=1, redirect_valid=1 and redirect_pc=RESET_PC.
REQ-029 SHALL, on the first clock edge after rst deasserts, drop flush and redirect_valid to 0, so fetch starts at RESET_PC.
REQ-030 SHALL abandon any pending register write or redirect when reset occurs mid-FLUSH or mid-commit.

Configuration
REQ-031 SHALL compile in, when macro WRITEBACK_INSTRET_EN is defined:
- output instret, 64 bits, reset to 0;
- instret increments by 1, wrapping modulo 2^64, for every RUN commit with trap=0, including commits with rd=0 or wb_en=0;
- instret does not increment for discarded or trapped results.
REQ-032 SHALL, when WRITEBACK_INSTRET_EN is undefined, contain no instret port or counter logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover a register write: result{wb_en=1, rd=5, rd_val=32'hDEAD_BEEF} -> the next cycle has rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF.
REQ-034 SHALL cover x0 suppression: result{wb_en=1, rd=0, rd_val=32'h1234} -> rf_we stays 0 (instret +1 when enabled).
REQ-035 SHALL cover a redirect followed by a wrong-path result, with both checks below:
- stimulus: result{redirect=1, redirect_pc=32'h8000_0040, wb_en=1, rd=1} in cycle N, then a valid result{wb_en=1, rd=2} in N+1;
- response: in N+1, flush=1, redirect_valid=1, redirect_pc=32'h8000_0040 and rf_we=1 for rd=1; in N+2, rf_we=0.
REQ-036 SHALL cover trap with redirect, with both checks below:
- stimulus: result{trap=1, redirect=1, wb_en=1, rd=3};
- response: the next cycle has flush=1, redirect_valid=0 and rf_we=0, then halted=1; 10 further valid results produce no rf_we.
REQ-037 SHALL cover reset out of HALT: rst pulsed asynchronously mid-cycle while in HALT -> immediately halted=0, redirect_valid=1, redirect_pc=RESET_PC; after release, the next result commits normally.
REQ-038 SHALL cover instret wrap with WRITEBACK_INSTRET_EN: instret preloaded to 64'hFFFF_FFFF_FFFF_FFFF, then one commit -> instret=0.
